// File: rtl/mem_bist_ctrl_if.sv
// Memory-side bus between the BIST controller (master) and a 16x8 memory
// whose read data is registered (valid one cycle after the address).
interface mem_bist_ctrl_if;
   logic       mem_write_enable;
   logic [7:0] mem_write_data;
   logic [3:0] mem_address;
   logic [7:0] mem_read_data;

   modport master (
      output mem_write_enable,
      output mem_write_data,
      output mem_address,
      input  mem_read_data
   );

   modport slave (
      input  mem_write_enable,
      input  mem_write_data,
      input  mem_address,
      output mem_read_data
   );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Write/read-back BIST for a 16x8 memory: writes seed XOR {a,~a} to every
// address, reads it back, and reports pass, mismatch count and first bad address.
module mem_bist_ctrl (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [7:0]             seed,
   mem_bist_ctrl_if.master        mem,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [4:0]             err_count,
   output logic [3:0]             first_err_addr
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      WRITE      = 2'd1,
      READ       = 2'd2,
      CHECK_LAST = 2'd3
   } state_e;

   state_e     state_q, state_d;
   logic [7:0] seed_q, seed_d;
   logic [3:0] addr_q, addr_d;
   logic       we_q, we_d;
   logic [7:0] wdata_q, wdata_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [4:0] err_count_q, err_count_d;
   logic [3:0] first_err_q, first_err_d;

   logic       cmp_en_s;
   logic [3:0] cmp_addr_s;
   logic       mismatch_s;

   function automatic logic [7:0] pattern(input logic [7:0] s, input logic [3:0] a);
      return s ^ {a, ~a};
   endfunction

   // Read data lags the issued address by one cycle, so compare against the previous address.
   always_comb begin
      cmp_en_s   = 1'b0;
      cmp_addr_s = 4'd0;
      case (state_q)
         READ: begin
            cmp_en_s   = (addr_q != 4'd0);
            cmp_addr_s = addr_q - 4'd1;
         end
         CHECK_LAST: begin
            cmp_en_s   = 1'b1;
            cmp_addr_s = 4'd15;
         end
         default: begin
            cmp_en_s   = 1'b0;
            cmp_addr_s = 4'd0;
         end
      endcase
      if (cmp_en_s) begin
         mismatch_s = (mem.mem_read_data != pattern(seed_q, cmp_addr_s));
      end else begin
         mismatch_s = 1'b0;
      end
   end

   // State register and all registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         seed_q      <= 8'd0;
         addr_q      <= 4'd0;
         we_q        <= 1'b0;
         wdata_q     <= 8'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         err_count_q <= 5'd0;
         first_err_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         seed_q      <= seed_d;
         addr_q      <= addr_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         err_count_q <= err_count_d;
         first_err_q <= first_err_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WRITE;
            end else begin
               state_d = IDLE;
            end
         end
         WRITE: begin
            if (addr_q == 4'd15) begin
               state_d = READ;
            end else begin
               state_d = WRITE;
            end
         end
         READ: begin
            if (addr_q == 4'd15) begin
               state_d = CHECK_LAST;
            end else begin
               state_d = READ;
            end
         end
         CHECK_LAST: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Next values of the registered outputs and the captured seed.
   always_comb begin
      seed_d      = seed_q;
      addr_d      = 4'd0;
      we_d        = 1'b0;
      wdata_d     = 8'd0;
      busy_d      = busy_q;
      done_d      = 1'b0;
      pass_d      = pass_q;
      err_count_d = err_count_q;
      first_err_d = first_err_q;

      // Addresses are checked in ascending order, so the first mismatch is the lowest.
      if (mismatch_s) begin
         err_count_d = err_count_q + 5'd1;
         if (err_count_q == 5'd0) begin
            first_err_d = cmp_addr_s;
         end else begin
            first_err_d = first_err_q;
         end
      end else begin
         err_count_d = err_count_q;
         first_err_d = first_err_q;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               seed_d      = seed;
               busy_d      = 1'b1;
               pass_d      = 1'b0;
               err_count_d = 5'd0;
               first_err_d = 4'd0;
               we_d        = 1'b1;
               addr_d      = 4'd0;
               wdata_d     = pattern(seed, 4'd0);
            end else begin
               busy_d = 1'b0;
            end
         end
         WRITE: begin
            if (addr_q == 4'd15) begin
               addr_d  = 4'd0;
               we_d    = 1'b0;
               wdata_d = 8'd0;
            end else begin
               addr_d  = addr_q + 4'd1;
               we_d    = 1'b1;
               wdata_d = pattern(seed_q, addr_q + 4'd1);
            end
         end
         READ: begin
            if (addr_q == 4'd15) begin
               addr_d = 4'd0;
            end else begin
               addr_d = addr_q + 4'd1;
            end
         end
         CHECK_LAST: begin
            busy_d = 1'b0;
            done_d = 1'b1;
            pass_d = (err_count_d == 5'd0);
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   assign mem.mem_write_enable = we_q;
   assign mem.mem_write_data   = wdata_q;
   assign mem.mem_address      = addr_q;
   assign busy                 = busy_q;
   assign done                 = done_q;
   assign pass                 = pass_q;
   assign err_count            = err_count_q;
   assign first_err_addr       = first_err_q;

endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  request one test run; sampled only in IDLE.
REQ-005 seed  input  8  pattern seed; captured on the accepted start.
REQ-006 mem_write_enable  output  1  to the 16x8 memory; 1 means write, 0 means read.
REQ-007 mem_write_data  output  8  write data to the memory.
REQ-008 mem_address  output  4  memory address.
REQ-009 mem_read_data  input  8  registered read data from the memory, valid one cycle after the read address is presented.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse at test completion.
REQ-012 pass  output  1  1 when the last completed run had zero mismatches; held until the next accepted start.
REQ-013 err_count  output  5  mismatch count for the last run (0-16); held until the next start.
REQ-014 first_err_addr  output  4  lowest mismatching address for the last run; 0 when there are no errors.

Function
REQ-015 The FSM SHALL have four states: IDLE, WRITE, READ and CHECK_LAST.
REQ-016 All outputs SHALL be registered.
REQ-017 The pattern SHALL be pattern(a) = seed_q XOR {a, ~a}, with seed_q captured at start (seed 0xA5: addr0=0xAA, addr5=0xFF).
REQ-018 IDLE with start=1: at that edge, capture seed, clear err_count, first_err_addr and pass, set busy=1, go to WRITE, and drive mem_write_enable=1, mem_address=0, mem_write_data=pattern(0).
REQ-019 WRITE: drive one address per cycle, 0..15 ascending.
REQ-020 After address 15 has been driven for one cycle, go to READ with mem_write_enable=0 and mem_address=0.
REQ-021 READ: issue one read address per cycle, 0..15.
REQ-022 In READ, from the second READ cycle onward, compare mem_read_data against pattern(current address - 1) each cycle.
REQ-023 After address 15 has been issued, go to CHECK_LAST, which compares address 15 data.
REQ-024 CHECK_LAST: return to IDLE with busy=0, done=1 for one cycle, and pass=(err_count_final==0).
REQ-025 Latency: the start-accept edge is E0; writes commit at E1..E16; compares occur at E18..E33; done is high in the cycle following E33, i.e. 34 cycles after start is accepted.
REQ-026 On mismatch: err_count SHALL increment by 1, with no saturation needed (maximum 16).
REQ-027 If err_count was 0 before the mismatch, first_err_addr SHALL take the mismatching address.
REQ-028 start while busy SHALL be ignored: no restart and no effect on counters.
REQ-029 start asserted in the same cycle that done is high SHALL be accepted, because the FSM is already in IDLE; the next run begins immediately.
REQ-030 In IDLE: mem_write_enable=0, mem_address=0, mem_write_data=0.
REQ-031 The address counter SHALL wrap 15→0 only on state transitions; it never exceeds 15.

Reset
REQ-032 rst=1 at any posedge SHALL force IDLE and set busy=0, done=0, pass=0, err_count=0, first_err_addr=0, mem_write_enable=0, mem_address=0, mem_write_data=0, seed_q=0.
REQ-033 rst SHALL take priority over start.
REQ-034 Reset mid-run SHALL abort the run without a done pulse; memory contents are then unspecified.
REQ-035 After rst deasserts, the first start SHALL run a complete test normally.

Verification
REQ-036 Fault-free 16x8 memory model, seed=0xA5, start pulsed -> done 34 cycles after accept, pass=1, err_count=0, first_err_addr=0; memory holds pattern(a) at every a.
REQ-037 Bit0 stuck-at-0 at addr5, seed=0xA5 (written 0xFF, read 0xFE) -> pass=0, err_count=1, first_err_addr=5.
REQ-038 Corrupt reads at addr3 and addr12, seed=0x00 -> err_count=2, first_err_addr=3, pass=0.
REQ-039 start re-pulsed at cycles 5 and 20 of a run -> ignored; done still occurs at cycle 34 and exactly one done pulse is seen.
REQ-040 rst asserted at cycle 8 of WRITE -> next cycle all outputs are at reset values and no done appears; a new start with seed=0x3C then passes.
REQ-041 start held high across done -> a second run starts in the done cycle, pass/err_count are cleared at accept, and the second done occurs 34 cycles later.
